// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, flag bit positions and the command
// sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SAR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_LAST = 4'b1010;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_C = 0;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_RESP  = 2'd3
  } seq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer. Head is the oldest entry, read
// combinationally; pushes are ignored when full and pops when empty.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import alu_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued ALU commands one at a time, captures the registered result
// and returns it with its tag; illegal opcodes are answered locally.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_a,
  input  logic [7:0]             cmd_b,
  input  logic [3:0]             cmd_op,
  input  logic [TAG_W-1:0]       cmd_tag,
  output logic                   alu_en,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_op,
  input  logic [7:0]             alu_out,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_data,
  output logic [3:0]             rsp_flags,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_err,
  output logic [$clog2(DEPTH):0] fifo_count
);
  import alu_pkg::*;

  localparam int FW = 20 + TAG_W;

  logic [FW-1:0]    head;
  logic [7:0]       head_a;
  logic [7:0]       head_b;
  logic [3:0]       head_op;
  logic [TAG_W-1:0] head_tag;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             dispatch;
  seq_state_e       state;

  assign {head_a, head_b, head_op, head_tag} = head;

  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  // A completed response hands straight over to the next head entry.
  assign dispatch  = (state == SEQ_IDLE) | ((state == SEQ_RESP) & rsp_ready);
  assign pop       = dispatch & ~empty;
  assign alu_en    = (state == SEQ_ISSUE);
  assign rsp_valid = (state == SEQ_RESP);

  alu_cmd_fifo #(
    .DEPTH(DEPTH),
    .W    (FW)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .wdata({cmd_a, cmd_b, cmd_op, cmd_tag}),
    .head (head),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEQ_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        SEQ_ISSUE: state <= SEQ_WAIT;
        // The ALU registered its result on the ISSUE edge.
        SEQ_WAIT: begin
          rsp_data  <= alu_out;
          rsp_flags <= alu_flags;
          rsp_err   <= 1'b0;
          state     <= SEQ_RESP;
        end
        default: begin
          if (dispatch) begin
            if (empty) begin
              state <= SEQ_IDLE;
            end else if (op_legal(head_op)) begin
              alu_a   <= head_a;
              alu_b   <= head_b;
              alu_op  <= head_op;
              rsp_tag <= head_tag;
              state   <= SEQ_ISSUE;
            end else begin
              rsp_data  <= '0;
              rsp_flags <= '0;
              rsp_err   <= 1'b1;
              rsp_tag   <= head_tag;
              state     <= SEQ_RESP;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: behavioural ALU, response scoreboard,
// directed latency/backpressure/reset cases and a randomized phase.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [7:0]             cmd_a = '0;
  logic [7:0]             cmd_b = '0;
  logic [3:0]             cmd_op = '0;
  logic [TAG_W-1:0]       cmd_tag = '0;
  logic                   alu_en;
  logic [7:0]             alu_a;
  logic [7:0]             alu_b;
  logic [3:0]             alu_op;
  logic [7:0]             alu_out;
  logic [3:0]             alu_flags;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [7:0]             rsp_data;
  logic [3:0]             rsp_flags;
  logic [TAG_W-1:0]       rsp_tag;
  logic                   rsp_err;
  logic [$clog2(DEPTH):0] fifo_count;

  typedef struct packed {
    logic             err;
    logic [7:0]       data;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   rsp_cnt = 0;
  rsp_t exp_q[$];
  int   rsp_cyc[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .alu_en    (alu_en),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_flags (alu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .fifo_count(fifo_count)
  );

  // Arithmetic definition of the ALU: {flags, result}.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic [3:0] f;
    logic       c;
    logic       v;
    s = '0; r = '0; f = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_SHL:  begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR:  begin r = {1'b0, a[7:1]}; c = a[0]; end
      OP_SAR:  begin r = {a[7], a[7:1]}; c = a[0]; end
      OP_SLTU: r = (a < b) ? 8'd1 : 8'd0;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      default: r = '0;
    endcase
    f[FLG_N] = r[7];
    f[FLG_Z] = (r == 8'd0);
    f[FLG_V] = v;
    f[FLG_C] = c;
    return {f, r};
  endfunction

  function automatic rsp_t expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] op, input logic [TAG_W-1:0] tag);
    rsp_t       e;
    logic [11:0] fr;
    e.tag = tag;
    if (op > OP_LAST) begin
      e.err = 1'b1; e.data = '0; e.flags = '0;
    end else begin
      fr = alu_model(a, b, op);
      e.err = 1'b0; e.data = fr[7:0]; e.flags = fr[11:8];
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Registered ALU sitting downstream of the DUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_flags, alu_out} <= '0;
    else if (alu_en) {alu_flags, alu_out} <= alu_model(alu_a, alu_b, alu_op);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: requests in order, responses must come back in the same order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) exp_q.push_back(expect_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
      if (alu_en) begin
        en_cnt++;
        if (alu_op > OP_LAST) check_eq("illegal_issue", 32'(alu_op), 32'(OP_LAST));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        rsp_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          check_eq("rsp", 32'({rsp_err, rsp_data, rsp_flags, rsp_tag}), 32'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                           input logic [TAG_W-1:0] tag);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
  endtask

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          input logic [TAG_W-1:0] tag);
    drive_cmd(a, b, op, tag);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (rsp_valid) lat = k;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    int   acc;
    int   base;
    int   sent;
    int   guard;
    logic ok;

    #12;
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_alu", 32'({alu_en, alu_a, alu_b, alu_op}), 32'd0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // ADD with signed overflow
    en_cnt = 0;
    send_one(8'h7F, 8'h01, OP_ADD, 4'd3);
    wait_rsp(lat);
    check_eq("add_latency", 32'(lat), 32'd3);
    check_eq("add_data", 32'(rsp_data), 32'h80);
    check_eq("add_flags", 32'(rsp_flags), 32'b1010);
    check_eq("add_tag", 32'(rsp_tag), 32'd3);
    check_eq("add_err", 32'(rsp_err), 32'd0);
    check_eq("add_en_pulses", 32'(en_cnt), 32'd1);
    handshake();

    // SUB with borrow
    send_one(8'h00, 8'h01, OP_SUB, 4'd5);
    wait_rsp(lat);
    check_eq("sub_latency", 32'(lat), 32'd3);
    check_eq("sub_data", 32'(rsp_data), 32'hFF);
    check_eq("sub_flags", 32'(rsp_flags), 32'b1001);
    handshake();

    // Illegal opcode is answered without touching the ALU
    tick();
    en_cnt = 0;
    send_one(8'h12, 8'h34, 4'b1100, 4'd7);
    wait_rsp(lat);
    check_eq("ill_latency", 32'(lat), 32'd1);
    check_eq("ill_rsp", 32'({rsp_err, rsp_data, rsp_flags, rsp_tag}), 32'({1'b1, 8'h00, 4'h0, 4'd7}));
    handshake();
    tick(); tick(); tick();
    check_eq("ill_no_en", 32'(en_cnt), 32'd0);

    // Backpressure: one in flight plus DEPTH queued
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 10)), 4'(acc));
      @(negedge clk);
      ok = cmd_ready;
      tick();
      if (ok) acc++;
    end
    cmd_valid = 1'b0;
    check_eq("bp_accepted", 32'(acc), 32'd5);
    check_eq("bp_ready_low", 32'(cmd_ready), 32'd0);
    check_eq("bp_count", 32'(fifo_count), 32'd4);
    base = rsp_cnt;
    rsp_ready = 1'b1;
    for (int k = 0; k < 100 && (rsp_cnt - base) < 5; k++) tick();
    check_eq("bp_rsp_cnt", 32'(rsp_cnt - base), 32'd5);
    check_eq("bp_ready_back", 32'(cmd_ready), 32'd1);
    check_eq("bp_count_empty", 32'(fifo_count), 32'd0);

    // Back-to-back ADDs with rsp_ready held high
    tick();
    rsp_cyc.delete();
    en_cnt = 0;
    for (int i = 0; i < 4; i++) send_one(8'($urandom), 8'($urandom), OP_ADD, 4'(8 + i));
    for (int k = 0; k < 40 && rsp_cyc.size() < 4; k++) tick();
    check_eq("b2b_rsp_cnt", 32'(rsp_cyc.size()), 32'd4);
    if (rsp_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) check_eq("b2b_gap", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
    check_eq("b2b_en_pulses", 32'(en_cnt), 32'd4);
    rsp_ready = 1'b0;

    // Asynchronous reset while a command sits in WAIT with another queued
    tick();
    drive_cmd(8'h21, 8'h43, OP_XOR, 4'd1);
    tick();
    drive_cmd(8'h55, 8'h0F, OP_AND, 4'd2);
    tick();
    cmd_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_alu", 32'({alu_en, alu_a, alu_b, alu_op}), 32'd0);
    check_eq("mid_rst_rsp", 32'({rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err}), 32'd0);
    check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
    check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    base = rsp_cnt;
    en_cnt = 0;
    repeat (10) tick();
    check_eq("post_rst_no_rsp", 32'(rsp_cnt - base), 32'd0);
    check_eq("post_rst_no_en", 32'(en_cnt), 32'd0);

    // Randomized traffic, including illegal opcodes and random backpressure
    sent = 0;
    guard = 0;
    while (sent < 60 && guard < 3000) begin
      if ($urandom_range(0, 2) != 0)
        drive_cmd(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom));
      else
        cmd_valid = 1'b0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (cmd_valid && cmd_ready) sent++;
      tick();
      guard++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check_eq("rand_sent", 32'(sent), 32'd60);
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) tick();
    tick();
    check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rand_count", 32'(fifo_count), 32'd0);
    check_eq("rand_idle", 32'(rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-issue stage directly upstream of the 8-bit registered ALU. Buffers tagged operation requests in a small FIFO and issues them one at a time to the ALU (operands, opcode, one-cycle enable). It captures the registered ALU result and status flags and returns them with the original tag over a valid/ready response channel. Opcodes the ALU does not implement are rejected locally with an error response and are never issued.

## Interface
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TAG_W, 4, width of the request/response tag

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  request valid
- cmd_ready  out  1  FIFO can accept a request
- cmd_a / cmd_b  in  8  operands
- cmd_op  in  4  ALU opcode
- cmd_tag  in  TAG_W  request tag
- alu_en  out  1  ALU enable; one-cycle pulse per issue
- alu_a / alu_b  out  8  registered operands to ALU
- alu_op  out  4  registered opcode to ALU
- alu_out  in  8  ALU registered result
- alu_flags  in  4  ALU flags {N,Z,V,C}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_data  out  8  result
- rsp_flags  out  4  flags {N,Z,V,C}
- rsp_tag  out  TAG_W  tag of the request
- rsp_err  out  1  illegal opcode (op > 4'b1010)
- fifo_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- A request is accepted on cmd_valid & cmd_ready. cmd_ready = (fifo_count < DEPTH). It depends on count only, so it stays low when full even if a pop occurs in the same cycle.
- Dispatch decision D, evaluated from the FIFO head:
  - empty → IDLE.
  - legal op (≤ 4'b1010) → ISSUE; load alu_a/b/op and tag from head, then pop.
  - illegal op → RESP with rsp_err=1, rsp_data=0, rsp_flags=0, rsp_tag=head tag; pop.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE: apply D every cycle.
  - ISSUE: alu_en=1 for exactly this cycle → WAIT.
  - WAIT: alu_out/alu_flags are valid; capture into rsp_data/rsp_flags with err=0 → RESP.
  - RESP: rsp_valid=1. Data, flags and tag are held stable until rsp_ready. On handshake, apply D, giving back-to-back issue without a pass through IDLE.
- alu_a/b/op hold their last value between issues. Only one operation is in flight at a time, and responses return in request order.
- Push and pop in the same cycle: fifo_count is unchanged. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values: all outputs 0, cmd_ready=1, FIFO empty, state IDLE. Reset is asynchronous and may occur mid-operation; an in-flight command and all queued commands are discarded. The ALU shares rst_n.
- Latency for a legal op into an idle block, counting edges after the accept edge E0:
  - E1: enter ISSUE.
  - E2: ALU registers the result; enter WAIT.
  - E3: capture; rsp_valid high after E3.
- Latency for an illegal op: rsp_valid high after E1.
- Sustained throughput with rsp_ready=1: one legal op per 3 cycles.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD..OP_SLT (4'b0000–4'b1010) and OP_LAST=4'b1010;
  - flag index constants FLG_N=3, FLG_Z=2, FLG_V=1, FLG_C=0;
  - the state enum for this block.
- Sub-module alu_cmd_fifo stores {a,b,op,tag}. Ports: push/pop, head, count, full/empty.

## Test plan
- ADD a=8'h7F b=8'h01 tag=3 → alu_en pulses once; rsp_valid 3 cycles after accept; rsp_data=8'h80, rsp_flags=4'b1010, rsp_tag=3, rsp_err=0.
- SUB a=8'h00 b=8'h01 → rsp_data=8'hFF, rsp_flags=4'b1001.
- Hold rsp_ready=0 and offer 8 requests (DEPTH=4) → exactly 5 accepted before cmd_ready falls. Release rsp_ready → 5 responses with tags in request order, and cmd_ready returns.
- Illegal op 4'b1100, tag=7 → alu_en never asserts; rsp_valid 1 cycle after accept; rsp_err=1, data=0, flags=0, tag=7.
- 4 back-to-back ADDs with rsp_ready=1 → responses spaced exactly 3 cycles apart, and alu_en pulses once per op.
- Assert rst_n low during WAIT → all outputs 0 immediately and fifo_count=0; no response appears after release.
